i2s_transmitter: RTL and testbench



---
 rtl/i2s_transmitter_pkg.sv | 31 +++
 rtl/i2s_transmitter_sample_fifo.sv | 77 +++++++
 rtl/i2s_transmitter.sv | 137 +++++++++++++
 tb/tb_i2s_transmitter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_transmitter_pkg.sv
// Shared sample type and I2S framing constants for the synth audio path.
// slot_bit maps a slot number to the SD bit that belongs in it.
package i2s_transmitter_pkg;

   localparam int SAMPLE_WIDTH        = 16;
   localparam int I2S_SLOTS_PER_FRAME = 32;
   localparam int SLOT_W              = $clog2(I2S_SLOTS_PER_FRAME);
   localparam int HALF_SLOTS          = I2S_SLOTS_PER_FRAME / 2;

   typedef logic signed [SAMPLE_WIDTH-1:0] Sample_t;
   typedef logic [SLOT_W-1:0]              slot_t;

   // Slot 0 carries the previous frame's LSB, so frame[0] is still the old word there.
   function automatic logic slot_bit(input slot_t slot, input Sample_t frame);
      logic [3:0] idx;
      logic       b;
      idx = 4'd0;
      b   = 1'b0;
      if (slot == 5'd0) begin
         b = frame[0];
      end else if (slot <= 5'd16) begin
         idx = 4'(5'd16 - slot);
         b   = frame[idx];
      end else begin
         idx = 4'(5'd0 - slot);
         b   = frame[idx];
      end
      return b;
   endfunction

endpackage

// File: rtl/i2s_transmitter_sample_fifo.sv
// Synchronous sample FIFO; a pop on empty is ignored, and a push on full is
// accepted only when a pop frees a slot on the same cycle.
module sample_fifo
   import i2s_transmitter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  Sample_t                  data_i,
   output Sample_t                  head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

   Sample_t     mem_q [DEPTH];
   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;
   logic [AW:0] level_q, level_d;
   logic        empty_s, full_s, do_push_s, do_pop_s;

   assign empty_s   = (wr_q == rd_q);
   assign full_s    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop_s  = pop_i & ~empty_s;
   assign do_push_s = push_i & (~full_s | do_pop_s);

   // Pointer and occupancy next-state.
   always_comb begin
      if (do_push_s) begin
         wr_d = wr_q + ONE;
      end else begin
         wr_d = wr_q;
      end
      if (do_pop_s) begin
         rd_d = rd_q + ONE;
      end else begin
         rd_d = rd_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   level_d = level_q + ONE;
         2'b01:   level_d = level_q - ONE;
         default: level_d = level_q;
      endcase
   end

   // Pointer and level registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
      end
   end

   // Storage array; on a full push+pop the head is read before this write lands.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_q[wr_q[AW-1:0]] <= data_i;
      end
   end

   assign head_o  = mem_q[rd_q[AW-1:0]];
   assign full_o  = full_s;
   assign empty_o = empty_s;
   assign level_o = level_q;

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S serializer: mono sample on both channels, BCLK divided from the
// system clock, WS/SD updated on BCLK falling events, samples fed by sample_fifo.
module i2s_transmitter
   import i2s_transmitter_pkg::*;
#(
   parameter int BCLK_HALF_PERIOD = 4,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                          i_Clock,
   input  logic                          i_Reset,
   input  Sample_t                       i_Sample,
   input  logic                          i_SampleReady,
   input  logic                          i_ClearFlags,
   output logic                          o_BitClock,
   output logic                          o_WordSelect,
   output logic                          o_SerialData,
   output logic                          o_Overflow,
   output logic                          o_Underflow,
   output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel
);

   localparam int               DIV_W    = $clog2(BCLK_HALF_PERIOD);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF_PERIOD - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             bclk_q, bclk_d;
   slot_t            slot_q, slot_d;
   logic             ws_q, ws_d;
   logic             sd_q, sd_d;
   Sample_t          frame_q, frame_d;
   logic             played_q, played_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic    fall_s, pop_req_s, pop_s;
   slot_t   slot_next_s;
   Sample_t head_s;
   logic    fifo_full_s, fifo_empty_s;

   sample_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (i_Clock),
      .rst_i   (i_Reset),
      .push_i  (i_SampleReady),
      .pop_i   (pop_req_s),
      .data_i  (i_Sample),
      .head_o  (head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .level_o (o_FifoLevel)
   );

   assign fall_s      = (div_q == DIV_LAST) & bclk_q;
   assign slot_next_s = slot_q + 5'd1;
   assign pop_req_s   = fall_s & (slot_next_s == 5'd0);
   assign pop_s       = pop_req_s & ~fifo_empty_s;

   // Serializer next-state: divider, slot, WS/SD, frame load and sticky flags.
   always_comb begin
      if (div_q == DIV_LAST) begin
         div_d  = '0;
         bclk_d = ~bclk_q;
      end else begin
         div_d  = div_q + DIV_ONE;
         bclk_d = bclk_q;
      end

      if (fall_s) begin
         slot_d = slot_next_s;
         ws_d   = (slot_next_s >= slot_t'(HALF_SLOTS));
         sd_d   = slot_bit(slot_next_s, frame_q);
      end else begin
         slot_d = slot_q;
         ws_d   = ws_q;
         sd_d   = sd_q;
      end

      // An empty FIFO at frame start keeps the old word so the last sample repeats.
      if (pop_s) begin
         frame_d  = head_s;
         played_d = 1'b1;
      end else begin
         frame_d  = frame_q;
         played_d = played_q;
      end

      if (i_SampleReady && fifo_full_s && !pop_s) begin
         ovf_d = 1'b1;
      end else if (i_ClearFlags) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      if (pop_req_s && fifo_empty_s && played_q) begin
         unf_d = 1'b1;
      end else if (i_ClearFlags) begin
         unf_d = 1'b0;
      end else begin
         unf_d = unf_q;
      end
   end

   // Serializer state registers; slot starts at 31 so the first falling event enters slot 0.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         div_q    <= '0;
         bclk_q   <= 1'b0;
         slot_q   <= slot_t'(I2S_SLOTS_PER_FRAME - 1);
         ws_q     <= 1'b0;
         sd_q     <= 1'b0;
         frame_q  <= '0;
         played_q <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         div_q    <= div_d;
         bclk_q   <= bclk_d;
         slot_q   <= slot_d;
         ws_q     <= ws_d;
         sd_q     <= sd_d;
         frame_q  <= frame_d;
         played_q <= played_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign o_BitClock   = bclk_q;
   assign o_WordSelect = ws_q;
   assign o_SerialData = sd_q;
   assign o_Overflow   = ovf_q;
   assign o_Underflow  = unf_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: idle framing, sample playback, repeat/underflow,
// overflow, simultaneous push/pop at frame start and mid-frame reset.
module tb_i2s_transmitter;

   logic        i_Clock;
   logic        i_Reset;
   logic [15:0] i_Sample;
   logic        i_SampleReady;
   logic        i_ClearFlags;
   logic        o_BitClock;
   logic        o_WordSelect;
   logic        o_SerialData;
   logic        o_Overflow;
   logic        o_Underflow;
   logic [2:0]  o_FifoLevel;

   i2s_transmitter #(
      .BCLK_HALF_PERIOD (4),
      .FIFO_DEPTH       (4)
   ) dut (
      .i_Clock       (i_Clock),
      .i_Reset       (i_Reset),
      .i_Sample      (i_Sample),
      .i_SampleReady (i_SampleReady),
      .i_ClearFlags  (i_ClearFlags),
      .o_BitClock    (o_BitClock),
      .o_WordSelect  (o_WordSelect),
      .o_SerialData  (o_SerialData),
      .o_Overflow    (o_Overflow),
      .o_Underflow   (o_Underflow),
      .o_FifoLevel   (o_FifoLevel)
   );

   initial i_Clock = 1'b0;
   always #5 i_Clock = ~i_Clock;

   typedef struct {
      logic [31:0] exp_sd;
      logic [2:0]  exp_level;
   } frame_vec_t;

   frame_vec_t  fv [9];
   logic [15:0] push_tab [5];
   int          total;
   int          bad;
   int          cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge i_Clock);
      cyc++;
      @(negedge i_Clock);
   endtask

   // Slot entered by the most recent falling event (edge 8k enters slot k-1).
   function automatic int exp_slot(input int c);
      if (c < 8) return -1;
      return ((c / 8) - 1) % 32;
   endfunction

   task automatic push(input logic [15:0] v);
      i_Sample      = v;
      i_SampleReady = 1'b1;
      tick();
      i_SampleReady = 1'b0;
   endtask

   task automatic clear_flags();
      i_ClearFlags = 1'b1;
      tick();
      i_ClearFlags = 1'b0;
   endtask

   task automatic run_to_slot(input int s);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!((cyc % 8 == 0) && exp_slot(cyc) == s) && n < 2100);
      if (n >= 2100) begin
         total++;
         bad++;
         $display("FAIL run_to_slot: cycle bound expired waiting for slot %0d", s);
      end
   endtask

   task automatic run_to_pre_slot0();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(((cyc + 1) % 8 == 0) && exp_slot(cyc + 1) == 0) && n < 2100);
      if (n >= 2100) begin
         total++;
         bad++;
         $display("FAIL run_to_pre_slot0: cycle bound expired");
      end
   endtask

   // Expects to be called just after the falling event entering slot 0.
   task automatic check_frame(input string name, input logic [31:0] exp_sd);
      logic [31:0] sd;
      logic [31:0] ws;
      for (int s = 0; s < 32; s++) begin
         sd[s] = o_SerialData;
         ws[s] = o_WordSelect;
         repeat (8) tick();
      end
      chk(name, sd, exp_sd);
      chk({name, "_ws"}, ws, 32'hFFFF0000);
   endtask

   task automatic check_idle(input int n);
      int s;
      for (int i = 0; i < n; i++) begin
         tick();
         s = exp_slot(cyc);
         chk("idle_bclk", 32'(o_BitClock), 32'((cyc / 4) % 2));
         chk("idle_ws", 32'(o_WordSelect), 32'(s >= 16));
         chk("idle_sd", 32'(o_SerialData), 32'd0);
         chk("idle_unf", 32'(o_Underflow), 32'd0);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;

      push_tab[0] = 16'h0001;
      push_tab[1] = 16'h0002;
      push_tab[2] = 16'h0003;
      push_tab[3] = 16'h0004;
      push_tab[4] = 16'h0005;
      // Overflow run: samples 1..4, level read at each frame start.
      fv[0] = '{32'h00010000, 3'd3};
      fv[1] = '{32'h80008001, 3'd2};
      fv[2] = '{32'h80018000, 3'd1};
      fv[3] = '{32'h40004001, 3'd0};
      // Full push+pop run: samples 1..5.
      fv[4] = '{32'h00010000, 3'd4};
      fv[5] = '{32'h80008001, 3'd3};
      fv[6] = '{32'h80018000, 3'd2};
      fv[7] = '{32'h40004001, 3'd1};
      fv[8] = '{32'h40014000, 3'd0};

      i_Reset       = 1'b1;
      i_Sample      = 16'h0000;
      i_SampleReady = 1'b0;
      i_ClearFlags  = 1'b0;
      @(negedge i_Clock);
      chk("rst_bclk", 32'(o_BitClock), 32'd0);
      chk("rst_ws", 32'(o_WordSelect), 32'd0);
      chk("rst_sd", 32'(o_SerialData), 32'd0);
      chk("rst_ovf", 32'(o_Overflow), 32'd0);
      chk("rst_unf", 32'(o_Underflow), 32'd0);
      chk("rst_level", 32'(o_FifoLevel), 32'd0);
      repeat (2) tick();
      i_Reset = 1'b0;
      cyc     = 0;

      // Idle: two full frames of silence plus the lead-in.
      check_idle(8 + 512);
      chk("idle_ovf", 32'(o_Overflow), 32'd0);

      // Single sample 0x8001, then repeat with underflow.
      push(16'h8001);
      chk("single_level_push", 32'(o_FifoLevel), 32'd1);
      run_to_slot(0);
      chk("single_level_pop", 32'(o_FifoLevel), 32'd0);
      check_frame("single", 32'h00030002);
      chk("single_unf", 32'(o_Underflow), 32'd1);
      check_frame("single_rep", 32'h00030003);
      clear_flags();
      chk("single_unf_clr", 32'(o_Underflow), 32'd0);

      // Underflow repeat with 0x1234.
      push(16'h1234);
      run_to_slot(0);
      chk("unf_first_start", 32'(o_Underflow), 32'd0);
      check_frame("unf_f1", 32'h58905891);
      chk("unf_second_start", 32'(o_Underflow), 32'd1);
      check_frame("unf_f2", 32'h58905890);
      check_frame("unf_f3", 32'h58905890);
      clear_flags();
      chk("unf_clr", 32'(o_Underflow), 32'd0);

      // Overflow: five pushes inside one frame, the fifth is dropped.
      for (int i = 0; i < 5; i++) push(push_tab[i]);
      chk("ovf_level", 32'(o_FifoLevel), 32'd4);
      chk("ovf_flag", 32'(o_Overflow), 32'd1);
      run_to_slot(0);
      for (int i = 0; i < 4; i++) begin
         chk("ovf_frame_level", 32'(o_FifoLevel), 32'(fv[i].exp_level));
         check_frame("ovf_frame", fv[i].exp_sd);
      end
      chk("ovf_drain_unf", 32'(o_Underflow), 32'd1);
      chk("ovf_sticky", 32'(o_Overflow), 32'd1);
      clear_flags();
      chk("ovf_clr", 32'(o_Overflow), 32'd0);
      chk("ovf_unf_clr", 32'(o_Underflow), 32'd0);

      // Full FIFO with a push exactly on the slot-0 falling event.
      for (int i = 0; i < 4; i++) push(push_tab[i]);
      run_to_pre_slot0();
      push(push_tab[4]);
      chk("simfull_ovf", 32'(o_Overflow), 32'd0);
      for (int i = 4; i < 9; i++) begin
         chk("simfull_level", 32'(o_FifoLevel), 32'(fv[i].exp_level));
         check_frame("simfull_frame", fv[i].exp_sd);
      end
      chk("simfull_drain_unf", 32'(o_Underflow), 32'd1);
      clear_flags();
      chk("simfull_unf_clr", 32'(o_Underflow), 32'd0);

      // Empty FIFO with a push exactly on the slot-0 falling event.
      run_to_pre_slot0();
      push(16'h1234);
      chk("simempty_unf", 32'(o_Underflow), 32'd1);
      chk("simempty_level", 32'(o_FifoLevel), 32'd1);
      check_frame("simempty_rep", 32'h40014001);
      chk("simempty_level_pop", 32'(o_FifoLevel), 32'd0);
      check_frame("simempty_play", 32'h58905891);

      // Mid-frame reset at slot 20 with BCLK high.
      run_to_slot(20);
      repeat (5) tick();
      chk("pre_rst_bclk", 32'(o_BitClock), 32'd1);
      chk("pre_rst_ws", 32'(o_WordSelect), 32'd1);
      chk("pre_rst_sd", 32'(o_SerialData), 32'd1);
      chk("pre_rst_unf", 32'(o_Underflow), 32'd1);
      i_Reset = 1'b1;
      #1;
      chk("midrst_bclk", 32'(o_BitClock), 32'd0);
      chk("midrst_ws", 32'(o_WordSelect), 32'd0);
      chk("midrst_sd", 32'(o_SerialData), 32'd0);
      chk("midrst_unf", 32'(o_Underflow), 32'd0);
      chk("midrst_ovf", 32'(o_Overflow), 32'd0);
      chk("midrst_level", 32'(o_FifoLevel), 32'd0);
      repeat (2) tick();
      i_Reset = 1'b0;
      cyc     = 0;
      check_idle(8 + 256 + 8);
      chk("post_rst_level", 32'(o_FifoLevel), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
